dff_register_bank: RTL

// - Parametrised successor to the single D flip-flop element: a WIDTH-bit D register with a

---
 rtl/dff_bank_pkg.sv | 12 +
 rtl/dff_word_stage.sv | 19 +
 rtl/dff_register_bank.sv | 92 +++++++++
 3 files changed

// File: rtl/dff_bank_pkg.sv
// dff_bank_pkg: shared types for the D register bank
// Provides the stage-0 operating mode encoding used by dff_register_bank.
package dff_bank_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_SHR  = 2'b11
    } mode_e;

endpackage

// File: rtl/dff_word_stage.sv
// dff_word_stage: WIDTH-bit D register with clock enable and async reset to RST_VAL
// Ports: clk, rst_n (async, active-low), en (load enable), d (next word), q (stored word).
module dff_word_stage #(
    parameter int                WIDTH   = 8,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= RST_VAL;
        else if (en) q <= d;
    end

endmodule

// File: rtl/dff_register_bank.sv
// dff_register_bank: WIDTH-bit storage bank with load/shift stage 0 and a STAGES-deep delay line
// Ports: clk, rst_n (async, active-low), en (bank enable), mode (HOLD/LOAD/SHL/SHR),
//        d (parallel data), ser_in (serial input), clr/set (sync clear/preset, override en),
//        q/q_n (last stage and its complement), ser_out (bit shifted out of stage 0),
//        valid (delay line fully filled), changed (q changed on the last edge).
module dff_register_bank
    import dff_bank_pkg::*;
#(
    parameter int                WIDTH   = 8,
    parameter int                STAGES  = 2,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    input  logic             clr,
    input  logic             set,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             ser_out,
    output logic             valid,
    output logic             changed
);

    localparam int             FW   = $clog2(STAGES + 1);
    localparam logic [FW-1:0]  FULL = FW'(STAGES);

    mode_e                        m;
    logic                         force_any;
    logic                         step;
    logic [WIDTH-1:0]             force_val;
    logic [WIDTH-1:0]             s0;
    logic [FW-1:0]                fill_cnt;
    logic [STAGES-1:0][WIDTH-1:0] stg;
    logic [STAGES-1:0][WIDTH-1:0] nxt;

    assign m         = mode_e'(mode);
    assign force_any = clr | set;
    assign force_val = clr ? '0 : '1;
    // clr/set must reach every stage even while the bank is stalled
    assign step      = en | force_any;
    assign stg[0]    = s0;

    // nxt holds the value each stage will have after the coming edge, so the
    // change strobe can compare the future q against the present one
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign nxt[0] = force_any        ? force_val :
                            !en              ? s0 :
                            m == MODE_LOAD   ? d :
                            m == MODE_SHL    ? {s0[WIDTH-2:0], ser_in} :
                            m == MODE_SHR    ? {ser_in, s0[WIDTH-1:1]} : s0;
        end else begin : g_delay
            assign nxt[i] = force_any ? force_val : en ? stg[i-1] : stg[i];
            dff_word_stage #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_VAL)
            ) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (step),
                .d     (nxt[i]),
                .q     (stg[i])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0       <= RST_VAL;
            ser_out  <= 1'b0;
            fill_cnt <= '0;
            changed  <= 1'b0;
        end else begin
            s0       <= nxt[0];
            changed  <= nxt[STAGES-1] != stg[STAGES-1];
            ser_out  <= force_any                ? 1'b0 :
                        en && m == MODE_SHL      ? s0[WIDTH-1] :
                        en && m == MODE_SHR      ? s0[0] : ser_out;
            fill_cnt <= force_any                ? FULL :
                        en && fill_cnt != FULL   ? fill_cnt + 1'b1 : fill_cnt;
        end
    end

    assign q     = stg[STAGES-1];
    assign q_n   = ~q;
    assign valid = fill_cnt == FULL;

endmodule
